// File: rtl/sumador_arbiter.sv
// Two-requester round-robin front end for a single sumador adder.
// Operands are latched at grant; the result and flags are registered and held until the consumer takes them.

module sumador #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] c,
  output logic [3:0]   banderas
);
  logic [n:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign c     = w_sum[n-1:0];
  // {N,Z,C,V}: V reports unsigned overflow, so it mirrors the carry out
  assign banderas = {w_sum[n-1], (w_sum[n-1:0] == '0), w_sum[n], w_sum[n]};
endmodule

module sumador_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [N-1:0] res_data,
  output logic [3:0]   res_flags,
  output logic         res_id,
  input  logic         res_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_accept;
  logic         w_sel1;
  logic         r_prio;
  logic         r_id;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_data;
  logic [3:0]   r_flags;
  logic [N-1:0] w_c;
  logic [3:0]   w_flags;

  sumador #(.n(N)) u_sumador (
    .a        (r_a),
    .b        (r_b),
    .c        (w_c),
    .banderas (w_flags)
  );

  // r_prio = 1 means req1 wins a tie; it only moves when a result is consumed
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_sel1   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept = 1'b1;
          w_sel1   = req1_valid && (!req0_valid || r_prio);
          w_next   = EXEC;
        end
      end
      EXEC:    w_next = RESP;
      RESP:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 1'b0;
      r_prio  <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= w_sel1 ? req1_a : req0_a;
        r_b  <= w_sel1 ? req1_b : req0_b;
        r_id <= w_sel1;
      end
      if (r_state == EXEC) begin
        r_data  <= w_c;
        r_flags <= w_flags;
      end
      if (r_state == RESP && res_ready) r_prio <= ~r_id;
    end
  end

  assign req0_ready = w_accept && !w_sel1;
  assign req1_ready = w_accept && w_sel1;
  assign res_valid  = (r_state == RESP);
  assign res_data   = r_data;
  assign res_flags  = r_flags;
  assign res_id     = r_id;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_sumador_arbiter.sv
// Scoreboard bench for sumador_arbiter: grants push expected results, consumed responses pop and compare.

module tb_sumador_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_id, busy;
  logic [3:0] res_data, res_flags;
  logic       res_ready = 1'b1;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] flags;
    logic       id;
  } resT;

  resT sbQ[$];
  int  grantLog[$];
  int  grantCyc[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  acceptCyc = 0;
  bit  latPending = 0;
  logic modelPrio = 1'b0;

  sumador_arbiter #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Expected flags {N,Z,C,V} with V as unsigned overflow: F+1 -> 0111, 7+1 -> 1000
  function automatic resT model(input logic [3:0] a, input logic [3:0] b, input logic id);
    logic [4:0] s;
    resT r;
    s = {1'b0, a} + {1'b0, b};
    r.data  = s[3:0];
    r.flags = {s[3], (s[3:0] == 4'd0), s[4], s[4]};
    r.id    = id;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic v1, input logic [3:0] a1, input logic [3:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    sbQ.delete();
    modelPrio  = 1'b0;
    latPending = 0;
  endtask

  task automatic doReset();
    assertReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitResult(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1;
    end
    checkOutput(tag, ok, 1);
  endtask

  // Monitor: grants feed the scoreboard, consumed results are compared against it
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready || req1_ready) begin
        checkOutput("one_ready", req0_ready & req1_ready, 0);
        checkOutput("ready_idle", busy, 0);
        if (req0_valid && req1_valid) checkOutput("rr_winner", req1_ready, modelPrio);
        if (req0_ready) sbQ.push_back(model(req0_a, req0_b, 1'b0));
        else            sbQ.push_back(model(req1_a, req1_b, 1'b1));
        grantLog.push_back(int'(req1_ready));
        grantCyc.push_back(cyc);
        acceptCyc  = cyc;
        latPending = 1;
      end
      if (res_valid && latPending) begin
        checkOutput("latency", cyc - acceptCyc, 2);
        latPending = 0;
      end
      if (res_valid && res_ready) begin
        checkOutput("sb_nonempty", (sbQ.size() != 0), 1);
        if (sbQ.size() != 0) begin
          resT e;
          e = sbQ.pop_front();
          checkOutput("res_data", res_data, e.data);
          checkOutput("res_flags", res_flags, e.flags);
          checkOutput("res_id", res_id, e.id);
          modelPrio = ~e.id;
        end
      end
    end
  end

  initial begin
    resT cap;
    logic g0, g1;

    // Reset state
    #2;
    checkOutput("rst_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data", res_data, 0);
    doReset();

    // Single op 3+4 from req0; operands changed after acceptance must not matter
    applyStimulus(1, 4'd3, 4'd4, 0, 4'd0, 4'd0);
    @(negedge clk);
    checkOutput("single_ready0", req0_ready, 1);
    nextCycle();
    applyStimulus(0, 4'd9, 4'd9, 0, 4'd0, 4'd0);
    waitResult("single_timeout");
    checkOutput("single_data", res_data, 4'd7);
    checkOutput("single_flags", res_flags, 4'b0000);
    checkOutput("single_id", res_id, 0);
    nextCycle();

    // Contention after reset: grants alternate 0,1,0,1 three cycles apart
    doReset();
    grantLog.delete();
    grantCyc.delete();
    applyStimulus(1, 4'd1, 4'd2, 1, 4'd5, 4'd6);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      nextCycle();
      if (g0) begin req0_a = 4'($urandom); req0_b = 4'($urandom); end
      if (g1) begin req1_a = 4'($urandom); req1_b = 4'($urandom); end
    end
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    repeat (4) nextCycle();
    checkOutput("contend_count", (grantLog.size() >= 4), 1);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) begin
      checkOutput("contend_order", grantLog[i], i % 2);
      if (i > 0) checkOutput("contend_spacing", grantCyc[i] - grantCyc[i-1], 3);
    end

    // Wrap-around and flags from req1
    applyStimulus(0, 4'd0, 4'd0, 1, 4'hF, 4'h1);
    @(negedge clk);
    checkOutput("wrap_ready1", req1_ready, 1);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    waitResult("wrap_timeout");
    checkOutput("wrap_data", res_data, 4'h0);
    checkOutput("wrap_flags", res_flags, 4'b0111);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 1, 4'h7, 4'h1);
    @(negedge clk);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    waitResult("ovf_timeout");
    checkOutput("ovf_data", res_data, 4'h8);
    checkOutput("ovf_flags", res_flags, 4'b1000);
    nextCycle();

    // Backpressure: response held for 5 cycles with a pending request waiting
    res_ready = 1'b0;
    applyStimulus(1, 4'd6, 4'd5, 0, 4'd0, 4'd0);
    @(negedge clk);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 1, 4'd2, 4'd2);
    waitResult("bp_timeout");
    cap = '{data: res_data, flags: res_flags, id: res_id};
    checkOutput("bp_data0", res_data, 4'hB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", res_valid, 1);
      checkOutput("bp_hold", {res_data, res_flags, res_id}, {cap.data, cap.flags, cap.id});
      checkOutput("bp_noready", {req0_ready, req1_ready}, 2'b00);
    end
    nextCycle();
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_done_noready", req1_ready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_next_grant", req1_ready, 1);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    waitResult("bp2_timeout");
    nextCycle();

    // Asynchronous reset mid-cycle while a req1 result is held
    res_ready = 1'b0;
    applyStimulus(0, 4'd0, 4'd0, 1, 4'd9, 4'd3);
    @(negedge clk);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    waitResult("arst_timeout");
    #2 assertReset();
    #1;
    checkOutput("arst_outs", {res_valid, res_data, res_flags, res_id, busy, req0_ready, req1_ready}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;

    // Reset during EXEC: in-flight op dropped and pointer returns to req0
    applyStimulus(1, 4'd2, 4'd2, 0, 4'd0, 4'd0);
    @(negedge clk);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    waitResult("exec_pre_timeout");
    nextCycle();
    applyStimulus(1, 4'd1, 4'd1, 1, 4'd5, 4'd5);
    @(negedge clk);
    checkOutput("exec_grant1", req1_ready, 1);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    #2 assertReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("exec_novalid", res_valid, 0);
    end
    nextCycle();
    applyStimulus(1, 4'd1, 4'd1, 1, 4'd5, 4'd5);
    @(negedge clk);
    checkOutput("exec_regrant0", req0_ready, 1);
    nextCycle();
    applyStimulus(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    waitResult("exec_post_timeout");
    nextCycle();
    repeat (2) nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
